// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload controller.
//   acc_prd_req_t / acc_prd_rsp_t : query/answer pair for the external predecoder
//   acc_state_e                   : offload controller FSM states
package acc_pkg;

    localparam int unsigned InstrWidth   = 32;
    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned NumRegs      = 32;
    localparam int unsigned MaxNumRs     = 3;

    typedef struct packed {
        logic [InstrWidth-1:0] q_instr_data;
    } acc_prd_req_t;

    typedef struct packed {
        logic                p_accept;
        logic                p_writeback;
        logic [MaxNumRs-1:0] p_use_rs;
    } acc_prd_rsp_t;

    typedef enum logic [1:0] {
        StIdle,
        StPredecode,
        StOperands,
        StOffload
    } acc_state_e;

    // Destination register field of an offloaded instruction.
    function automatic logic [RegAddrWidth-1:0] instr_rd(input logic [InstrWidth-1:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/acc_offload_ctrl_if.sv
// Bundle of all handshake/bus signals around the offload controller.
//   core_req_*  : offload request from the core (instr, operands, per-operand valid)
//   core_flush_i: abort of a not-yet-issued offload
//   core_rsp_*  : one-cycle accept/reject decision pulse
//   prd_*       : predecoder query/answer (predecoder lives outside the controller)
//   acc_req_*   : request towards the accelerator
//   acc_rsp_*   : writeback from the accelerator
//   core_wb_*   : writeback forwarded to the core
// The slave modport is the controller's view; master is the environment's view.
interface acc_offload_ctrl_if
    import acc_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRs     = 3
) ();

    logic                             core_req_valid_i;
    logic                             core_req_ready_o;
    logic [InstrWidth-1:0]            core_req_instr_i;
    logic [NumRs-1:0][DataWidth-1:0]  core_req_rs_i;
    logic [NumRs-1:0]                 core_req_rs_valid_i;
    logic                             core_flush_i;
    logic                             core_rsp_valid_o;
    logic                             core_rsp_accept_o;

    acc_prd_req_t                     prd_req_o;
    acc_prd_rsp_t                     prd_rsp_i;

    logic                             acc_req_valid_o;
    logic                             acc_req_ready_i;
    logic [InstrWidth-1:0]            acc_req_instr_o;
    logic [NumRs-1:0][DataWidth-1:0]  acc_req_rs_o;

    logic                             acc_rsp_valid_i;
    logic                             acc_rsp_ready_o;
    logic [RegAddrWidth-1:0]          acc_rsp_rd_i;
    logic [DataWidth-1:0]             acc_rsp_data_i;

    logic                             core_wb_valid_o;
    logic                             core_wb_ready_i;
    logic [RegAddrWidth-1:0]          core_wb_rd_o;
    logic [DataWidth-1:0]             core_wb_data_o;

    modport slave (
        input  core_req_valid_i, core_req_instr_i, core_req_rs_i, core_req_rs_valid_i,
        input  core_flush_i, prd_rsp_i, acc_req_ready_i,
        input  acc_rsp_valid_i, acc_rsp_rd_i, acc_rsp_data_i, core_wb_ready_i,
        output core_req_ready_o, core_rsp_valid_o, core_rsp_accept_o, prd_req_o,
        output acc_req_valid_o, acc_req_instr_o, acc_req_rs_o,
        output acc_rsp_ready_o, core_wb_valid_o, core_wb_rd_o, core_wb_data_o
    );

    modport master (
        output core_req_valid_i, core_req_instr_i, core_req_rs_i, core_req_rs_valid_i,
        output core_flush_i, prd_rsp_i, acc_req_ready_i,
        output acc_rsp_valid_i, acc_rsp_rd_i, acc_rsp_data_i, core_wb_ready_i,
        input  core_req_ready_o, core_rsp_valid_o, core_rsp_accept_o, prd_req_o,
        input  acc_req_valid_o, acc_req_instr_o, acc_req_rs_o,
        input  acc_rsp_ready_o, core_wb_valid_o, core_wb_rd_o, core_wb_data_o
    );

endinterface

// File: rtl/acc_scoreboard.sv
// Busy-register tracker for destination registers of in-flight offloads.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   set_valid_i/set_idx_i  : mark a register busy (wins over a same-cycle clear)
//   clr_valid_i/clr_idx_i  : mark a register free
//   busy_o                 : registered busy vector, bit 0 is always 0
module acc_scoreboard
    import acc_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    set_valid_i,
    input  logic [RegAddrWidth-1:0] set_idx_i,
    input  logic                    clr_valid_i,
    input  logic [RegAddrWidth-1:0] clr_idx_i,
    output logic [NumRegs-1:0]      busy_o
);

    logic [NumRegs-1:0] busy_q;
    logic [NumRegs-1:0] busy_d;
    logic [NumRegs-1:0] set_mask;
    logic [NumRegs-1:0] clr_mask;

    // Clear first, then set, so a new owner survives a retiring one.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid_i) set_mask[set_idx_i] = 1'b1;
        if (clr_valid_i) clr_mask[clr_idx_i] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/acc_offload_ctrl.sv
// Offload controller between a core and an accelerator: registers the request,
// asks the external predecoder, waits for operands and a free destination
// register, issues to the accelerator and forwards writebacks to the core.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : all handshake signals (see acc_offload_ctrl_if), slave view
module acc_offload_ctrl
    import acc_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRs     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    acc_offload_ctrl_if.slave bus
);

    acc_state_e                      state_q, state_d;
    logic [InstrWidth-1:0]           instr_q, instr_d;
    logic                            wb_q, wb_d;
    logic [NumRs-1:0]                use_rs_q, use_rs_d;
    logic [NumRs-1:0][DataWidth-1:0] rs_q, rs_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic                            rsp_accept_q, rsp_accept_d;

    logic [NumRegs-1:0]              busy;
    logic [RegAddrWidth-1:0]         rd;
    logic                            operands_ready;
    logic                            rd_hazard;
    logic                            acc_hs;
    logic                            sb_set;
    logic                            sb_clr;

    assign rd             = instr_rd(instr_q);
    assign operands_ready = &(~use_rs_q | bus.core_req_rs_valid_i);
    assign rd_hazard      = wb_q & busy[rd];
    assign acc_hs         = (state_q == StOffload) & bus.acc_req_ready_i;
    assign sb_set         = acc_hs & wb_q & (rd != '0);
    assign sb_clr         = bus.acc_rsp_valid_i & bus.core_wb_ready_i;

    // Next-state and register updates.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        wb_d         = wb_q;
        use_rs_d     = use_rs_q;
        rs_d         = rs_q;
        rsp_valid_d  = 1'b0;
        rsp_accept_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.core_req_valid_i) begin
                    instr_d = bus.core_req_instr_i;
                    state_d = StPredecode;
                end
            end
            StPredecode: begin
                if (bus.core_flush_i) begin
                    state_d = StIdle;
                end else if (!bus.prd_rsp_i.p_accept) begin
                    rsp_valid_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    wb_d     = bus.prd_rsp_i.p_writeback;
                    use_rs_d = bus.prd_rsp_i.p_use_rs[NumRs-1:0];
                    state_d  = StOperands;
                end
            end
            StOperands: begin
                if (bus.core_flush_i) begin
                    state_d = StIdle;
                end else if (operands_ready && !rd_hazard) begin
                    // Unused operand slots go out as zero.
                    for (int unsigned i = 0; i < NumRs; i++) begin
                        rs_d[i] = use_rs_q[i] ? bus.core_req_rs_i[i] : '0;
                    end
                    state_d = StOffload;
                end
            end
            StOffload: begin
                // Flush is ignored here: a raised valid is never retracted.
                if (bus.acc_req_ready_i) begin
                    rsp_valid_d  = 1'b1;
                    rsp_accept_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            instr_q      <= '0;
            wb_q         <= 1'b0;
            use_rs_q     <= '0;
            rs_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_accept_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            wb_q         <= wb_d;
            use_rs_q     <= use_rs_d;
            rs_q         <= rs_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_accept_q <= rsp_accept_d;
        end
    end

    acc_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_valid_i (sb_set),
        .set_idx_i   (rd),
        .clr_valid_i (sb_clr),
        .clr_idx_i   (bus.acc_rsp_rd_i),
        .busy_o      (busy)
    );

    assign bus.core_req_ready_o       = (state_q == StIdle);
    assign bus.core_rsp_valid_o       = rsp_valid_q;
    assign bus.core_rsp_accept_o      = rsp_accept_q;
    assign bus.prd_req_o.q_instr_data = instr_q;
    assign bus.acc_req_valid_o        = (state_q == StOffload);
    assign bus.acc_req_instr_o        = instr_q;
    assign bus.acc_req_rs_o           = rs_q;

    // Writeback path is a pure pass-through.
    assign bus.core_wb_valid_o        = bus.acc_rsp_valid_i;
    assign bus.acc_rsp_ready_o        = bus.core_wb_ready_i;
    assign bus.core_wb_rd_o           = bus.acc_rsp_rd_i;
    assign bus.core_wb_data_o         = bus.acc_rsp_data_i;

endmodule

// File: tb/tb_acc_offload_ctrl.sv
// Directed bench for acc_offload_ctrl with a decision/issue scoreboard.
module tb_acc_offload_ctrl;
    import acc_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 3;

    typedef struct packed {
        logic [31:0]          instr;
        logic [NR-1:0][DW-1:0] rs;
    } acc_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_offload_ctrl_if #(.DataWidth(DW), .NumRs(NR)) bus ();

    acc_offload_ctrl #(.DataWidth(DW), .NumRs(NR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Predecoder model: opcode 0x2B accepted, bit31 = writeback, bits30:28 = use_rs.
    assign bus.prd_rsp_i.p_accept    = (bus.prd_req_o.q_instr_data[6:0] == 7'h2B);
    assign bus.prd_rsp_i.p_writeback = bus.prd_req_o.q_instr_data[31];
    assign bus.prd_rsp_i.p_use_rs    = bus.prd_req_o.q_instr_data[30:28];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          rsp_q[$];
    acc_exp_t    acc_q[$];

    localparam logic [31:0] RsA = 32'hAAAA_0000;
    localparam logic [31:0] RsB = 32'hBBBB_0001;
    localparam logic [31:0] RsC = 32'hCCCC_0002;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit wb, input bit [2:0] use_rs, input bit [4:0] rd);
        return {wb, use_rs, 16'h0000, rd, 7'h2B};
    endfunction

    function automatic logic [31:0] busy5();
        logic [31:0] b;
        b = dut.u_scoreboard.busy_o;
        return 32'(b[5]);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr);
        chk("req_ready_idle", 128'(bus.core_req_ready_o), 128'd1);
        bus.core_req_valid_i = 1'b1;
        bus.core_req_instr_i = instr;
        @(posedge clk);
        #1;
        bus.core_req_valid_i = 1'b0;
        bus.core_req_instr_i = 32'h0;
    endtask

    // Scoreboard side: pop expectations when the DUT produces decisions/issues.
    always @(negedge clk) begin
        if (bus.core_rsp_valid_o === 1'b1) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 128'(bus.core_rsp_valid_o), 128'd0);
            end else begin
                automatic bit e = rsp_q.pop_front();
                chk("rsp_accept", 128'(bus.core_rsp_accept_o), 128'(e));
            end
        end
        if (bus.acc_req_valid_o === 1'b1 && bus.acc_req_ready_i === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("acc_unexpected", 128'(bus.acc_req_valid_o), 128'd0);
            end else begin
                automatic acc_exp_t e = acc_q.pop_front();
                chk("acc_instr", 128'(bus.acc_req_instr_o), 128'(e.instr));
                chk("acc_rs", 128'(bus.acc_req_rs_o), 128'(e.rs));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        logic [31:0] i1, i2, i3, i4, i5, i6, i7;
        bus.core_req_valid_i    = 1'b0;
        bus.core_req_instr_i    = 32'h0;
        bus.core_req_rs_i       = {RsC, RsB, RsA};
        bus.core_req_rs_valid_i = 3'b111;
        bus.core_flush_i        = 1'b0;
        bus.acc_req_ready_i     = 1'b1;
        bus.acc_rsp_valid_i     = 1'b0;
        bus.acc_rsp_rd_i        = 5'd0;
        bus.acc_rsp_data_i      = 32'h0;
        bus.core_wb_ready_i     = 1'b1;

        // Reset state
        step(2);
        chk("busy_in_reset", 128'(dut.u_scoreboard.busy_o), 128'd0);
        rst = 1'b0;
        step(1);
        chk("rst_req_ready", 128'(bus.core_req_ready_o), 128'd1);
        chk("rst_acc_valid", 128'(bus.acc_req_valid_o), 128'd0);
        chk("rst_rsp_valid", 128'(bus.core_rsp_valid_o), 128'd0);
        chk("rst_wb_valid", 128'(bus.core_wb_valid_o), 128'd0);

        // Reject: decision 2 cycles after handshake
        rsp_q.push_back(1'b0);
        issue(32'h0000_000B);
        chk("rej_ready_busy", 128'(bus.core_req_ready_o), 128'd0);
        chk("rej_rsp_early", 128'(bus.core_rsp_valid_o), 128'd0);
        step(1);
        chk("rej_rsp_valid", 128'(bus.core_rsp_valid_o), 128'd1);
        chk("rej_rsp_accept", 128'(bus.core_rsp_accept_o), 128'd0);
        chk("rej_no_acc", 128'(bus.acc_req_valid_o), 128'd0);
        step(1);
        chk("rej_pulse_end", 128'(bus.core_rsp_valid_o), 128'd0);
        chk("rej_back_idle", 128'(bus.core_req_ready_o), 128'd1);

        // Accepted rd=5 use_rs=011: issue 3 cycles after handshake
        i1 = mk(1'b1, 3'b011, 5'd5);
        rsp_q.push_back(1'b1);
        acc_q.push_back('{instr: i1, rs: {32'h0, RsB, RsA}});
        issue(i1);
        chk("acc1_lat1", 128'(bus.acc_req_valid_o), 128'd0);
        step(1);
        chk("acc1_lat2", 128'(bus.acc_req_valid_o), 128'd0);
        step(1);
        chk("acc1_valid", 128'(bus.acc_req_valid_o), 128'd1);
        chk("acc1_rs2_zero", 128'(bus.acc_req_rs_o[2]), 128'd0);
        bus.core_req_rs_i[0] = 32'hDEAD_BEEF;
        step(1);
        bus.core_req_rs_i[0] = RsA;
        chk("acc1_done", 128'(bus.acc_req_valid_o), 128'd0);
        chk("acc1_rsp", 128'(bus.core_rsp_valid_o), 128'd1);
        chk("acc1_busy5", 128'(busy5()), 128'd1);

        // Same rd while busy: stall until writeback of rd=5
        i2 = mk(1'b1, 3'b001, 5'd5);
        rsp_q.push_back(1'b1);
        acc_q.push_back('{instr: i2, rs: {32'h0, 32'h0, RsA}});
        issue(i2);
        step(5);
        chk("stall_no_acc", 128'(bus.acc_req_valid_o), 128'd0);
        chk("stall_not_ready", 128'(bus.core_req_ready_o), 128'd0);
        bus.acc_rsp_valid_i = 1'b1;
        bus.acc_rsp_rd_i    = 5'd5;
        bus.acc_rsp_data_i  = 32'h1234_5678;
        #1;
        chk("wb_valid_fwd", 128'(bus.core_wb_valid_o), 128'd1);
        chk("wb_rd_fwd", 128'(bus.core_wb_rd_o), 128'd5);
        chk("wb_data_fwd", 128'(bus.core_wb_data_o), 128'h1234_5678);
        chk("wb_ready_fwd", 128'(bus.acc_rsp_ready_o), 128'd1);
        step(1);
        bus.acc_rsp_valid_i = 1'b0;
        chk("stall_busy_clr", 128'(busy5()), 128'd0);
        chk("stall_still", 128'(bus.acc_req_valid_o), 128'd0);
        step(1);
        chk("stall_release", 128'(bus.acc_req_valid_o), 128'd1);
        step(1);
        chk("stall_busy_set", 128'(busy5()), 128'd1);

        // Simultaneous set and clear of rd=5 leaves it set
        bus.acc_rsp_valid_i = 1'b1;
        step(1);
        bus.acc_rsp_valid_i = 1'b0;
        chk("sim_pre_clr", 128'(busy5()), 128'd0);
        bus.acc_req_ready_i = 1'b0;
        i3 = mk(1'b1, 3'b100, 5'd5);
        rsp_q.push_back(1'b1);
        acc_q.push_back('{instr: i3, rs: {RsC, 32'h0, 32'h0}});
        issue(i3);
        step(2);
        chk("sim_offload", 128'(bus.acc_req_valid_o), 128'd1);
        bus.acc_req_ready_i = 1'b1;
        bus.acc_rsp_valid_i = 1'b1;
        bus.acc_rsp_rd_i    = 5'd5;
        step(1);
        bus.acc_rsp_valid_i = 1'b0;
        chk("sim_busy5_set", 128'(busy5()), 128'd1);

        // Writeback of a non-busy rd is forwarded, busy vector unchanged
        bus.acc_rsp_valid_i = 1'b1;
        bus.acc_rsp_rd_i    = 5'd9;
        bus.acc_rsp_data_i  = 32'h0000_CAFE;
        bus.core_wb_ready_i = 1'b0;
        #1;
        chk("nb_ready_low", 128'(bus.acc_rsp_ready_o), 128'd0);
        bus.core_wb_ready_i = 1'b1;
        #1;
        chk("nb_wb_rd", 128'(bus.core_wb_rd_o), 128'd9);
        step(1);
        bus.acc_rsp_valid_i = 1'b0;
        chk("nb_busy_same", 128'(dut.u_scoreboard.busy_o), 128'h20);

        // Flush in OPERANDS
        bus.core_req_rs_valid_i = 3'b000;
        i4 = mk(1'b1, 3'b010, 5'd7);
        issue(i4);
        step(2);
        chk("fop_waiting", 128'(bus.core_req_ready_o), 128'd0);
        bus.core_flush_i = 1'b1;
        step(1);
        bus.core_flush_i = 1'b0;
        bus.core_req_rs_valid_i = 3'b111;
        chk("fop_idle", 128'(bus.core_req_ready_o), 128'd1);
        chk("fop_no_rsp", 128'(bus.core_rsp_valid_o), 128'd0);
        step(2);
        chk("fop_no_rsp2", 128'(bus.core_rsp_valid_o), 128'd0);
        chk("fop_no_acc", 128'(bus.acc_req_valid_o), 128'd0);

        // Flush in PREDECODE
        i5 = mk(1'b0, 3'b001, 5'd3);
        issue(i5);
        bus.core_flush_i = 1'b1;
        step(1);
        bus.core_flush_i = 1'b0;
        chk("fpd_idle", 128'(bus.core_req_ready_o), 128'd1);
        step(1);
        chk("fpd_no_rsp", 128'(bus.core_rsp_valid_o), 128'd0);

        // Flush in OFFLOAD ignored, valid held while ready low; rd=0 never busy
        bus.acc_req_ready_i = 1'b0;
        i6 = mk(1'b1, 3'b111, 5'd0);
        rsp_q.push_back(1'b1);
        acc_q.push_back('{instr: i6, rs: {RsC, RsB, RsA}});
        issue(i6);
        step(2);
        bus.core_flush_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("foff_hold", 128'(bus.acc_req_valid_o), 128'd1);
            step(1);
        end
        bus.core_flush_i    = 1'b0;
        bus.acc_req_ready_i = 1'b1;
        chk("foff_still", 128'(bus.acc_req_valid_o), 128'd1);
        step(1);
        chk("foff_done", 128'(bus.acc_req_valid_o), 128'd0);
        chk("foff_rsp", 128'(bus.core_rsp_valid_o), 128'd1);
        chk("rd0_not_busy", 128'(dut.u_scoreboard.busy_o), 128'h20);

        // Reset in OFFLOAD
        bus.acc_req_ready_i = 1'b0;
        i7 = mk(1'b1, 3'b001, 5'd6);
        issue(i7);
        step(2);
        chk("roff_valid", 128'(bus.acc_req_valid_o), 128'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("roff_dropped", 128'(bus.acc_req_valid_o), 128'd0);
        chk("roff_busy_zero", 128'(dut.u_scoreboard.busy_o), 128'd0);
        chk("roff_no_rsp", 128'(bus.core_rsp_valid_o), 128'd0);
        step(1);
        chk("roff_ready", 128'(bus.core_req_ready_o), 128'd1);
        chk("roff_no_rsp2", 128'(bus.core_rsp_valid_o), 128'd0);

        step(2);
        chk("rsp_q_drained", 128'(rsp_q.size()), 128'd0);
        chk("acc_q_drained", 128'(acc_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_offload_ctrl.md
ACC_OFFLOAD_CTRL -- requirements
Module: acc_offload_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32, operand/result width.
REQ-002 SHALL have parameter NumRs, default 3, source operands per instruction.
REQ-003 SHALL have ports clk_i (in, 1, single clock) and rst_i (in, 1, reset is synchronous and active-high).
REQ-004 SHALL have core_req_valid_i in 1, core_req_ready_o out 1, core_req_instr_i in 32: offload request from core.
REQ-005 SHALL have core_req_rs_i in NumRs x DataWidth and core_req_rs_valid_i in NumRs: operand values and per-operand valid.
REQ-006 SHALL have core_flush_i in 1: abort pending non-issued offload.
REQ-007 SHALL have core_rsp_valid_o out 1 and core_rsp_accept_o out 1: one-cycle decision pulse.
REQ-008 SHALL have prd_req_o out acc_prd_req_t and prd_rsp_i in acc_prd_rsp_t: combinational predecoder query/answer.
REQ-009 SHALL have acc_req_valid_o out 1, acc_req_ready_i in 1, acc_req_instr_o out 32, acc_req_rs_o out NumRs x DataWidth: accelerator request.
REQ-010 SHALL have acc_rsp_valid_i in 1, acc_rsp_ready_o out 1, acc_rsp_rd_i in 5, acc_rsp_data_i in DataWidth: accelerator writeback.
REQ-011 SHALL have core_wb_valid_o out 1, core_wb_ready_i in 1, core_wb_rd_o out 5, core_wb_data_o out DataWidth: writeback to core.

Function
REQ-012 SHALL implement FSM IDLE, PREDECODE, OPERANDS, OFFLOAD.
REQ-013 core_req_ready_o SHALL be 1 only in IDLE; on core handshake, instr SHALL be registered and FSM SHALL enter PREDECODE.
REQ-014 prd_req_o.q_instr_data SHALL be driven from the instr register (no combinational path from core_req_instr_i).
REQ-015 In PREDECODE, p_accept=0 SHALL pulse core_rsp_valid_o with core_rsp_accept_o=0 and return to IDLE; p_accept=1 SHALL register p_writeback, p_use_rs and enter OPERANDS.
REQ-016 OPERANDS SHALL exit when, for every i with use_rs[i]=1, core_req_rs_valid_i[i]=1, and (p_writeback=0 or rd=instr[11:7] not busy); operands SHALL be latched on exit; FSM SHALL enter OFFLOAD.
REQ-017 In OFFLOAD, acc_req_valid_o SHALL be 1 with stable instr/rs until acc_req_ready_i; on handshake core_rsp_valid_o SHALL pulse with core_rsp_accept_o=1, FSM SHALL return to IDLE.
REQ-018 Unused operands (use_rs[i]=0) SHALL be driven as zero on acc_req_rs_o.
REQ-019 On OFFLOAD handshake with p_writeback=1 and rd!=0, busy[rd] SHALL be set next cycle; rd=0 SHALL never be busy.
REQ-020 Writeback SHALL pass through combinationally: core_wb_valid_o=acc_rsp_valid_i, acc_rsp_ready_o=core_wb_ready_i, rd/data forwarded.
REQ-021 Writeback handshake SHALL clear busy[acc_rsp_rd_i] next cycle; simultaneous set and clear of same rd SHALL leave it set.
REQ-022 core_flush_i in PREDECODE or OPERANDS SHALL return FSM to IDLE without core_rsp pulse; in OFFLOAD flush SHALL be ignored (valid not retracted); in IDLE no effect.
REQ-023 Latency: reject decision 2 cycles after request handshake; earliest acc_req_valid_o 3 cycles after.
REQ-024 Writeback for a non-busy rd SHALL be forwarded and leave scoreboard unchanged.

Reset
REQ-025 rst_i SHALL force FSM IDLE, busy all zero, instr/operand registers zero; all valid outputs 0, core_req_ready_o 1 the cycle after reset deasserts.
REQ-026 Reset mid-OFFLOAD SHALL drop acc_req_valid_o next cycle without core_rsp pulse.

Structure
REQ-027 acc_prd_req_t, acc_prd_rsp_t and FSM state enum SHALL live in acc_pkg.
REQ-028 The 32-entry busy-register tracker SHALL be a sub-module acc_scoreboard (set/clear ports, busy vector out).
REQ-029 The predecoder SHALL be instantiated outside this block.

Verification
REQ-030 Instr 0x0000_000B, p_accept=0 -> core_rsp_valid_o pulse 2 cycles later with accept=0, no acc_req_valid_o.
REQ-031 Accepted instr rd=5, use_rs=3'b011, rs valid at once, acc_req_ready_i=1 -> acc_req_valid_o 3 cycles after handshake, rs_o[2]=0, busy[5]=1.
REQ-032 busy[5]=1, second writeback instr with rd=5 -> stalls in OPERANDS until acc_rsp rd=5 handshake, then offloads.
REQ-033 Writeback rd=5 handshake in same cycle as new offload rd=5 handshake -> busy[5]=1 afterwards.
REQ-034 core_flush_i in OPERANDS -> IDLE, no core_rsp pulse; flush in OFFLOAD with acc_req_ready_i=0 for 4 cycles -> valid held until ready.
REQ-035 rst_i in OFFLOAD -> acc_req_valid_o 0 next cycle, busy vector zero.
